// File: rtl/ysyx_22040000_alu_issue.sv
// ALU issue stage: decodes RV32I OP/OP-IMM/LUI/AUIPC into an ALU select and operands,
// drives the external combinational ALU from stage 1 and registers its result in stage 2.
`ifndef ALUOP_WIDTH
`define ALUOP_WIDTH 4
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_SLL  4'd2
`define ALU_SLT  4'd3
`define ALU_SLTU 4'd4
`define ALU_XOR  4'd5
`define ALU_SRL  4'd6
`define ALU_SRA  4'd7
`define ALU_OR   4'd8
`define ALU_AND  4'd9
`define ALU_B    4'd10
`endif

module ysyx_22040000_alu_issue #(
    parameter int DWIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_inst,
    input  logic [DWIDTH-1:0]       in_pc,
    input  logic [DWIDTH-1:0]       in_rs1_data,
    input  logic [DWIDTH-1:0]       in_rs2_data,
    output logic [`ALUOP_WIDTH-1:0] alu_sel,
    output logic [DWIDTH-1:0]       alu_a,
    output logic [DWIDTH-1:0]       alu_b,
    input  logic [DWIDTH-1:0]       alu_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DWIDTH-1:0]       out_result,
    output logic [4:0]              out_rd,
    output logic                    out_wen,
    output logic                    out_illegal
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    generate
        if (DWIDTH != 32) begin : g_width_check
            $error("ysyx_22040000_alu_issue supports DWIDTH = 32 only");
        end
    endgenerate

    function automatic logic [`ALUOP_WIDTH-1:0] base_sel(input logic [2:0] f3);
        case (f3)
            3'b000:  base_sel = `ALU_ADD;
            3'b001:  base_sel = `ALU_SLL;
            3'b010:  base_sel = `ALU_SLT;
            3'b011:  base_sel = `ALU_SLTU;
            3'b100:  base_sel = `ALU_XOR;
            3'b101:  base_sel = `ALU_SRL;
            3'b110:  base_sel = `ALU_OR;
            default: base_sel = `ALU_AND;
        endcase
    endfunction

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;
    logic [DWIDTH-1:0] imm_i;
    logic [DWIDTH-1:0] imm_u;

    assign opcode = in_inst[6:0];
    assign f3     = in_inst[14:12];
    assign f7     = in_inst[31:25];
    assign rd     = in_inst[11:7];
    assign imm_i  = {{(DWIDTH-12){in_inst[31]}}, in_inst[31:20]};
    assign imm_u  = DWIDTH'({in_inst[31:12], 12'b0});

    logic [`ALUOP_WIDTH-1:0] dec_sel;
    logic [DWIDTH-1:0]       dec_a;
    logic [DWIDTH-1:0]       dec_b;
    logic                    dec_ill;

    always_comb begin
        dec_sel = `ALU_ADD;
        dec_a   = '0;
        dec_b   = '0;
        dec_ill = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_a = in_rs1_data;
                dec_b = in_rs2_data;
                if (f7 == 7'h00)                        dec_sel = base_sel(f3);
                else if (f7 == 7'h20 && f3 == 3'b000)   dec_sel = `ALU_SUB;
                else if (f7 == 7'h20 && f3 == 3'b101)   dec_sel = `ALU_SRA;
                else                                    dec_ill = 1'b1;
            end
            OPC_IMM: begin
                dec_a   = in_rs1_data;
                dec_b   = imm_i;
                dec_sel = base_sel(f3);
                // Shift immediates reuse imm[11:5] as funct7; the ALU only looks at b[4:0].
                if (f3 == 3'b001 && f7 != 7'h00) begin
                    dec_ill = 1'b1;
                end else if (f3 == 3'b101) begin
                    if (f7 == 7'h20)      dec_sel = `ALU_SRA;
                    else if (f7 != 7'h00) dec_ill = 1'b1;
                end
            end
            OPC_LUI: begin
                dec_sel = `ALU_B;
                dec_b   = imm_u;
            end
            OPC_AUIPC: begin
                dec_a = in_pc;
                dec_b = imm_u;
            end
            default: dec_ill = 1'b1;
        endcase
        if (dec_ill) begin
            dec_sel = `ALU_ADD;
            dec_a   = '0;
            dec_b   = '0;
        end
    end

    logic                    vld_p1;
    logic [`ALUOP_WIDTH-1:0] sel_p1;
    logic [DWIDTH-1:0]       a_p1;
    logic [DWIDTH-1:0]       b_p1;
    logic [4:0]              rd_p1;
    logic                    wen_p1;
    logic                    ill_p1;

    logic                    vld_p2;
    logic [DWIDTH-1:0]       result_p2;
    logic [4:0]              rd_p2;
    logic                    wen_p2;
    logic                    ill_p2;

    logic s1_adv;
    logic accept;

    assign s1_adv   = vld_p1 && (!vld_p2 || out_ready);
    assign in_ready = !vld_p1 || s1_adv;
    assign accept   = in_valid && in_ready;

    // Stage 1: decoded operation held for the external ALU
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            sel_p1 <= '0;
            a_p1   <= '0;
            b_p1   <= '0;
            rd_p1  <= '0;
            wen_p1 <= 1'b0;
            ill_p1 <= 1'b0;
        end else begin
            if (flush)         vld_p1 <= 1'b0;
            else if (in_ready) vld_p1 <= in_valid;
            if (accept) begin
                sel_p1 <= dec_sel;
                a_p1   <= dec_a;
                b_p1   <= dec_b;
                rd_p1  <= rd;
                wen_p1 <= !dec_ill && (rd != 5'd0);
                ill_p1 <= dec_ill;
            end
        end
    end

    // Stage 2: captured ALU result awaiting writeback
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p2    <= 1'b0;
            result_p2 <= '0;
            rd_p2     <= '0;
            wen_p2    <= 1'b0;
            ill_p2    <= 1'b0;
        end else begin
            if (flush)       vld_p2 <= 1'b0;
            else if (s1_adv) vld_p2 <= 1'b1;
            else             vld_p2 <= vld_p2 && !out_ready;
            if (s1_adv) begin
                result_p2 <= ill_p1 ? '0 : alu_out;
                rd_p2     <= rd_p1;
                wen_p2    <= wen_p1;
                ill_p2    <= ill_p1;
            end
        end
    end

    assign alu_sel     = sel_p1;
    assign alu_a       = a_p1;
    assign alu_b       = b_p1;
    assign out_valid   = vld_p2;
    assign out_result  = result_p2;
    assign out_rd      = rd_p2;
    assign out_wen     = wen_p2;
    assign out_illegal = ill_p2;

endmodule

// File: tb/tb_ysyx_22040000_alu_issue.sv
// Bench for ysyx_22040000_alu_issue: directed RV32I cases, a stalled stream and a
// random stream scored against an instruction-level reference model.
`ifndef ALUOP_WIDTH
`define ALUOP_WIDTH 4
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_SLL  4'd2
`define ALU_SLT  4'd3
`define ALU_SLTU 4'd4
`define ALU_XOR  4'd5
`define ALU_SRL  4'd6
`define ALU_SRA  4'd7
`define ALU_OR   4'd8
`define ALU_AND  4'd9
`define ALU_B    4'd10
`endif

module tb_ysyx_22040000_alu_issue;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                    reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]             in_inst, in_pc, in_rs1_data, in_rs2_data;
    logic [`ALUOP_WIDTH-1:0] alu_sel;
    logic [31:0]             alu_a, alu_b, alu_out, out_result;
    logic [4:0]              out_rd;
    logic                    out_wen, out_illegal;

    ysyx_22040000_alu_issue #(.DWIDTH(32)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_wen(out_wen), .out_illegal(out_illegal)
    );

    // External combinational ALU
    always_comb begin
        case (alu_sel)
            `ALU_ADD:  alu_out = alu_a + alu_b;
            `ALU_SUB:  alu_out = alu_a - alu_b;
            `ALU_SLL:  alu_out = alu_a << alu_b[4:0];
            `ALU_SLT:  alu_out = {31'b0, $signed(alu_a) < $signed(alu_b)};
            `ALU_SLTU: alu_out = {31'b0, alu_a < alu_b};
            `ALU_XOR:  alu_out = alu_a ^ alu_b;
            `ALU_SRL:  alu_out = alu_a >> alu_b[4:0];
            `ALU_SRA:  alu_out = $signed(alu_a) >>> alu_b[4:0];
            `ALU_OR:   alu_out = alu_a | alu_b;
            `ALU_AND:  alu_out = alu_a & alu_b;
            `ALU_B:    alu_out = alu_b;
            default:   alu_out = 32'h0;
        endcase
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        wen;
        logic        ill;
    } exp_t;

    // Architectural result of one instruction
    function automatic exp_t ref_model(input logic [31:0] inst, pc, r1, r2);
        exp_t e;
        logic [31:0] imm = {{20{inst[31]}}, inst[31:20]};
        logic [31:0] uimm = {inst[31:12], 12'b0};
        logic signed [31:0] s1 = r1;
        logic [2:0] f3 = inst[14:12];
        logic [6:0] f7 = inst[31:25];
        e.ill = 1'b0;
        e.res = 32'h0;
        e.rd  = inst[11:7];
        case (inst[6:0])
            7'b0110011: begin
                if (f7 == 7'h00) begin
                    case (f3)
                        3'd0: e.res = r1 + r2;
                        3'd1: e.res = r1 << r2[4:0];
                        3'd2: e.res = ($signed(r1) < $signed(r2)) ? 32'd1 : 32'd0;
                        3'd3: e.res = (r1 < r2) ? 32'd1 : 32'd0;
                        3'd4: e.res = r1 ^ r2;
                        3'd5: e.res = r1 >> r2[4:0];
                        3'd6: e.res = r1 | r2;
                        default: e.res = r1 & r2;
                    endcase
                end else if (f7 == 7'h20 && f3 == 3'd0) e.res = r1 - r2;
                else if (f7 == 7'h20 && f3 == 3'd5)    e.res = s1 >>> r2[4:0];
                else                                   e.ill = 1'b1;
            end
            7'b0010011: begin
                case (f3)
                    3'd0: e.res = r1 + imm;
                    3'd1: if (f7 == 7'h00) e.res = r1 << inst[24:20]; else e.ill = 1'b1;
                    3'd2: e.res = ($signed(r1) < $signed(imm)) ? 32'd1 : 32'd0;
                    3'd3: e.res = (r1 < imm) ? 32'd1 : 32'd0;
                    3'd4: e.res = r1 ^ imm;
                    3'd5: begin
                        if (f7 == 7'h00)      e.res = r1 >> inst[24:20];
                        else if (f7 == 7'h20) e.res = s1 >>> inst[24:20];
                        else                  e.ill = 1'b1;
                    end
                    3'd6: e.res = r1 | imm;
                    default: e.res = r1 & imm;
                endcase
            end
            7'b0110111: e.res = uimm;
            7'b0010111: e.res = pc + uimm;
            default:    e.ill = 1'b1;
        endcase
        if (e.ill) e.res = 32'h0;
        e.wen = !e.ill && (e.rd != 5'd0);
        return e;
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [31:0] w = $urandom;
        int k = $urandom_range(0, 9);
        logic [6:0] f7;
        case ($urandom_range(0, 3))
            0, 1:    f7 = 7'h00;
            2:       f7 = 7'h20;
            default: f7 = 7'($urandom);
        endcase
        if (k <= 3)      w = {f7, w[24:7], 7'b0110011};
        else if (k <= 6) w = {f7, w[24:7], 7'b0010011};
        else if (k == 7) w[6:0] = 7'b0110111;
        else if (k == 8) w[6:0] = 7'b0010111;
        return w;
    endfunction

    task automatic run_single(input string tag, input logic [31:0] inst, pc, r1, r2,
                              input logic [31:0] exp_res, input logic [4:0] exp_rd,
                              input logic exp_wen, input logic exp_ill);
        in_inst = inst; in_pc = pc; in_rs1_data = r1; in_rs2_data = r2;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_lat"}, out_valid, 0);
        tick();
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_result"}, out_result, exp_res);
        chk({tag, "_rd"}, out_rd, exp_rd);
        chk({tag, "_wen"}, out_wen, exp_wen);
        chk({tag, "_illegal"}, out_illegal, exp_ill);
        tick();
    endtask

    exp_t q[$];
    int   inflight = 0;
    int   blocked_cycles = 0;

    // mode 0: continuous input, out_ready low cycles 3..5; 1: random; 2: drain only
    task automatic run_stream(input int ncycles, input int limit, input int mode);
        int sent = 0;
        logic hold = 1'b0;
        logic [31:0] h_res;
        logic [4:0]  h_rd;
        logic        h_wen, h_ill;
        for (int c = 0; c < ncycles; c++) begin
            logic fire_in, fire_out;
            if (mode == 0)      out_ready = !(c >= 3 && c <= 5);
            else if (mode == 1) out_ready = ($urandom_range(0, 3) != 0);
            else                out_ready = 1'b1;
            if (!in_valid && sent < limit && (mode == 0 || $urandom_range(0, 3) != 0)) begin
                in_inst = gen_inst(); in_pc = $urandom;
                in_rs1_data = $urandom; in_rs2_data = $urandom;
                in_valid = 1'b1;
            end
            @(negedge clock);
            chk("in_ready", in_ready, !(inflight == 2 && !out_ready));
            if (inflight == 2 && !in_ready) blocked_cycles++;
            if (hold) begin
                chk("stall_result", out_result, h_res);
                chk("stall_rd", out_rd, h_rd);
                chk("stall_wen", out_wen, h_wen);
                chk("stall_illegal", out_illegal, h_ill);
            end
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (out_valid && q.size() == 0) chk("spurious_valid", out_valid, 0);
            else if (fire_out) begin
                exp_t e = q.pop_front();
                chk("stream_result", out_result, e.res);
                chk("stream_rd", out_rd, e.rd);
                chk("stream_wen", out_wen, e.wen);
                chk("stream_illegal", out_illegal, e.ill);
                inflight--;
            end
            hold = out_valid && !out_ready;
            h_res = out_result; h_rd = out_rd; h_wen = out_wen; h_ill = out_illegal;
            if (fire_in) begin
                q.push_back(ref_model(in_inst, in_pc, in_rs1_data, in_rs2_data));
                inflight++;
                sent++;
            end
            @(posedge clock);
            #1;
            if (fire_in) in_valid = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = 32'h0; in_pc = 32'h0; in_rs1_data = 32'h0; in_rs2_data = 32'h0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_alu_sel", alu_sel, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_result", out_result, 0);
        chk("rst_rd", out_rd, 0);
        chk("rst_wen", out_wen, 0);
        chk("rst_illegal", out_illegal, 0);
        chk("rst_in_ready", in_ready, 1);

        run_single("addi_m1", 32'hFFF00293, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 5'd5, 1'b1, 1'b0);
        run_single("sra", 32'h4020D1B3, 32'h0, 32'h80000000, 32'd4, 32'hF8000000, 5'd3, 1'b1, 1'b0);
        run_single("srl", 32'h0020D1B3, 32'h0, 32'h80000000, 32'd4, 32'h08000000, 5'd3, 1'b1, 1'b0);
        run_single("auipc", 32'h12345097, 32'h80000000, 32'h0, 32'h0, 32'h92345000, 5'd1, 1'b1, 1'b0);
        run_single("lui_x0", 32'h00001037, 32'h0, 32'h0, 32'h0, 32'h00001000, 5'd0, 1'b0, 1'b0);
        run_single("ecall", 32'h00000073, 32'h0, 32'h5, 32'h6, 32'h0, 5'd0, 1'b0, 1'b1);
        run_single("op_f7_01", 32'h022081B3, 32'h0, 32'h11, 32'h22, 32'h0, 5'd3, 1'b0, 1'b1);
        run_single("srai_bad", 32'h6010D193, 32'h0, 32'h80000000, 32'h0, 32'h0, 5'd3, 1'b0, 1'b1);

        // Eight back-to-back instructions with a three-cycle writeback stall
        run_stream(14, 8, 0);
        run_stream(10, 0, 2);
        chk("stream8_drained", q.size(), 0);
        chk("stream8_blocked", (blocked_cycles > 0) ? 32'd1 : 32'd0, 1);

        run_stream(300, 200, 1);
        run_stream(10, 0, 2);
        chk("random_drained", q.size(), 0);

        // Flush with both stages full and a new input offered
        out_ready = 1'b0;
        in_inst = 32'h00100093; in_rs1_data = 32'h1; in_valid = 1'b1;
        tick();
        in_inst = 32'h00200113;
        tick();
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        in_inst = 32'h00300193; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        tick();
        chk("flush_dropped", out_valid, 0);
        chk("flush_alu_a_known", (^alu_a === 1'bx) ? 32'd1 : 32'd0, 0);

        // Reset while stalled with both stages full
        out_ready = 1'b0;
        in_inst = 32'h7FF08293; in_rs1_data = 32'h1234; in_valid = 1'b1;
        tick();
        in_inst = 32'h4020D1B3; in_rs1_data = 32'h80000000; in_rs2_data = 32'd4;
        tick();
        chk("prereset_out_valid", out_valid, 1);
        reset = 1'b1;
        tick();
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_alu_sel", alu_sel, 0);
        chk("mrst_alu_a", alu_a, 0);
        chk("mrst_alu_b", alu_b, 0);
        chk("mrst_result", out_result, 0);
        chk("mrst_rd", out_rd, 0);
        chk("mrst_wen", out_wen, 0);
        chk("mrst_illegal", out_illegal, 0);
        reset = 1'b0; in_valid = 1'b0;
        #1;
        chk("mrst_in_ready", in_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
